// File: rtl/hwag_pkg.sv
// hwag_pkg: shared defaults and types for the angle-window output bank.
// Optional build macro used by the bank: HWAG_OUT_SHADOW_EN.
package hwag_pkg;

  localparam int ACNT_WIDTH_DEF = 24;
  localparam int ACNT_TOP_DEF   = 7679;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    ARMED = 2'd1,
    ON    = 2'd2
  } chan_state_e;

  // Width of a channel index; a single channel still gets a 1-bit index.
  function automatic int ch_idx_width(input int ch_num);
    return (ch_num > 1) ? $clog2(ch_num) : 1;
  endfunction

endpackage

// File: rtl/hwag_out_chan.sv
// hwag_out_chan: one angle-window output channel. Holds the turn-on/turn-off
// angles and the enable, compares them with the stepping angle count and runs
// the OFF/ARMED/ON sequencer. With HWAG_OUT_SHADOW_EN defined, writes land in
// shadow registers and reach the active set only when copy_en is high.
module hwag_out_chan
  import hwag_pkg::*;
#(
  parameter int ACNT_WIDTH = ACNT_WIDTH_DEF,
  parameter int ACNT_TOP   = ACNT_TOP_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hwag_start,
  input  logic [ACNT_WIDTH-1:0] acnt,
  input  logic                  acnt_step,
`ifdef HWAG_OUT_SHADOW_EN
  input  logic                  copy_en,
`endif
  input  logic                  wr_hit,
  input  logic [ACNT_WIDTH-1:0] wr_set,
  input  logic [ACNT_WIDTH-1:0] wr_rst,
  input  logic                  wr_chen,
  output logic                  out,
  output logic                  armed
);

  localparam logic [ACNT_WIDTH-1:0] TOP_VAL = ACNT_WIDTH'(ACNT_TOP);

  logic [ACNT_WIDTH-1:0] on_ang;
  logic [ACNT_WIDTH-1:0] off_ang;
  logic                  chan_en;
  logic                  on_hit;
  logic                  off_hit;
  chan_state_e           state_q;
  chan_state_e           state_d;

`ifdef HWAG_OUT_SHADOW_EN
  logic [ACNT_WIDTH-1:0] on_ang_sh;
  logic [ACNT_WIDTH-1:0] off_ang_sh;
  logic                  chan_en_sh;

  // Writes fill the shadow; the copy takes the shadow as it was before any
  // write in the same cycle, so a coinciding write waits for the next copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      on_ang_sh  <= '0;
      off_ang_sh <= '0;
      chan_en_sh <= 1'b0;
      on_ang     <= '0;
      off_ang    <= '0;
      chan_en    <= 1'b0;
    end else begin
      if (wr_hit) begin
        on_ang_sh  <= wr_set;
        off_ang_sh <= wr_rst;
        chan_en_sh <= wr_chen;
      end
      if (copy_en) begin
        on_ang  <= on_ang_sh;
        off_ang <= off_ang_sh;
        chan_en <= chan_en_sh;
      end
    end
  end
`else
  // Writes update the active configuration directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      on_ang  <= '0;
      off_ang <= '0;
      chan_en <= 1'b0;
    end else if (wr_hit) begin
      on_ang  <= wr_set;
      off_ang <= wr_rst;
      chan_en <= wr_chen;
    end
  end
`endif

  // Angles beyond the end of the cycle can never be reached, so they never match.
  assign on_hit  = acnt_step && (acnt == on_ang)  && (on_ang  <= TOP_VAL);
  assign off_hit = acnt_step && (acnt == off_ang) && (off_ang <= TOP_VAL);

  // Next-state logic: losing sync or enable drops straight to OFF.
  always_comb begin
    state_d = state_q;
    if (!hwag_start || !chan_en) begin
      state_d = OFF;
    end else begin
      case (state_q)
        OFF:     state_d = ARMED;
        ARMED:   if (on_hit)  state_d = ON;
        ON:      if (off_hit) state_d = ARMED;
        default: state_d = OFF;
      endcase
    end
  end

  // State register with outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OFF;
      out     <= 1'b0;
      armed   <= 1'b0;
    end else begin
      state_q <= state_d;
      out     <= (state_d == ON);
      armed   <= (state_d != OFF);
    end
  end

endmodule

// File: rtl/hwag_out_bank.sv
// hwag_out_bank: bank of CH_NUM angle-window outputs driven by the angle
// generator count. Optional build macro HWAG_OUT_SHADOW_EN buffers channel
// writes in shadow registers transferred at the end of each angle cycle.
module hwag_out_bank
  import hwag_pkg::*;
#(
  parameter int CH_NUM     = 4,
  parameter int ACNT_WIDTH = ACNT_WIDTH_DEF,
  parameter int ACNT_TOP   = ACNT_TOP_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              hwag_start,
  input  logic [ACNT_WIDTH-1:0]             acnt,
  input  logic                              acnt_step,
  input  logic                              wr_ena,
  input  logic [ch_idx_width(CH_NUM)-1:0]   wr_ch,
  input  logic [ACNT_WIDTH-1:0]             wr_set,
  input  logic [ACNT_WIDTH-1:0]             wr_rst,
  input  logic                              wr_chen,
  output logic [CH_NUM-1:0]                 out,
  output logic [CH_NUM-1:0]                 armed
);

`ifdef HWAG_OUT_SHADOW_EN
  logic copy_en;

  // Shadow transfer at the last angle of the cycle, or continuously while unsynchronised.
  assign copy_en = (acnt_step && (acnt == ACNT_WIDTH'(ACNT_TOP))) || !hwag_start;
`endif

  for (genvar i = 0; i < CH_NUM; i++) begin : g_chan
    logic wr_hit;

    // Only existing channel indices decode, so out-of-range writes fall away.
    assign wr_hit = wr_ena && (int'(wr_ch) == i);

    hwag_out_chan #(
      .ACNT_WIDTH (ACNT_WIDTH),
      .ACNT_TOP   (ACNT_TOP)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .hwag_start (hwag_start),
      .acnt       (acnt),
      .acnt_step  (acnt_step),
`ifdef HWAG_OUT_SHADOW_EN
      .copy_en    (copy_en),
`endif
      .wr_hit     (wr_hit),
      .wr_set     (wr_set),
      .wr_rst     (wr_rst),
      .wr_chen    (wr_chen),
      .out        (out[i]),
      .armed      (armed[i])
    );
  end

endmodule

// File: tb/tb_hwag_out_bank.sv
// tb_hwag_out_bank: self-checking bench for hwag_out_bank with three channels
// (so that index 3 is an out-of-range channel). Angles step through the full
// cycle with random idle cycles carrying junk acnt values; a behavioural model
// of armed/on per channel tracks every cycle, and per-scenario tasks check
// pulse positions and widths computed from the configured angles.
// Honours HWAG_OUT_SHADOW_EN in the same way as the design.
module tb_hwag_out_bank;

  localparam int CH  = 3;
  localparam int AW  = 24;
  localparam int TOP = 7679;
  localparam int N   = TOP + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          hwag_start;
  logic [AW-1:0] acnt;
  logic          acnt_step;
  logic          wr_ena;
  logic [1:0]    wr_ch;
  logic [AW-1:0] wr_set;
  logic [AW-1:0] wr_rst;
  logic          wr_chen;
  logic [CH-1:0] out;
  logic [CH-1:0] armed;

  int errors = 0;
  int checks = 0;

  // model of the configuration and of each channel's armed/on status
  int a_set[CH];
  int a_off[CH];
  bit a_en[CH];
  int s_set[CH];
  int s_off[CH];
  bit s_en[CH];
  bit m_on[CH];
  bit m_arm[CH];

  // angle bookkeeping and observed events
  int cur_ang = 0;
  int last_ang = 0;
  int trace_bad = 0;
  int bad_ang = 0;
  logic [CH-1:0] bad_out, bad_exp, bad_arm, bad_earm;
  logic [CH-1:0] prev_out = '0;
  int rise_cnt[CH];
  int rise_ang[CH];
  int high_steps[CH];
  int fall_q[CH][$];

  always #5 clk = ~clk;

  hwag_out_bank #(
    .CH_NUM     (CH),
    .ACNT_WIDTH (AW),
    .ACNT_TOP   (TOP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hwag_start (hwag_start),
    .acnt       (acnt),
    .acnt_step  (acnt_step),
    .wr_ena     (wr_ena),
    .wr_ch      (wr_ch),
    .wr_set     (wr_set),
    .wr_rst     (wr_rst),
    .wr_chen    (wr_chen),
    .out        (out),
    .armed      (armed)
  );

  // expected number of steps the output stays high for a window
  function automatic int exp_width(input int set_a, input int off_a);
    return (set_a == off_a) ? N : ((off_a - set_a + N) % N);
  endfunction

  // advance the model by one clock edge using the inputs held over that edge
  task automatic model_edge();
    bit copy;
    int wc;
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        a_set[c] = 0; a_off[c] = 0; a_en[c] = 0;
        s_set[c] = 0; s_off[c] = 0; s_en[c] = 0;
        m_on[c] = 0; m_arm[c] = 0;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (!hwag_start || !a_en[c]) begin
          m_arm[c] = 0;
          m_on[c]  = 0;
        end else if (!m_arm[c]) begin
          m_arm[c] = 1;
        end else if (!m_on[c]) begin
          if (acnt_step && int'(acnt) == a_set[c]) m_on[c] = 1;
        end else begin
          if (acnt_step && int'(acnt) == a_off[c]) m_on[c] = 0;
        end
      end
      wc = int'(wr_ch);
`ifdef HWAG_OUT_SHADOW_EN
      copy = (acnt_step && int'(acnt) == TOP) || !hwag_start;
      if (copy) begin
        for (int c = 0; c < CH; c++) begin
          a_set[c] = s_set[c]; a_off[c] = s_off[c]; a_en[c] = s_en[c];
        end
      end
      if (wr_ena && wc < CH) begin
        s_set[wc] = int'(wr_set); s_off[wc] = int'(wr_rst); s_en[wc] = wr_chen;
      end
`else
      copy = 0;
      if (wr_ena && wc < CH && !copy) begin
        a_set[wc] = int'(wr_set); a_off[wc] = int'(wr_rst); a_en[wc] = wr_chen;
      end
`endif
    end
  endtask

  // one clock: update the model, then sample the DUT 1 time unit after the edge
  task automatic tick();
    logic [CH-1:0] exp_out;
    logic [CH-1:0] exp_arm;
    int ang;
    @(posedge clk);
    model_edge();
    ang = acnt_step ? int'(acnt) : last_ang;
    #1;
    for (int c = 0; c < CH; c++) begin
      exp_out[c] = m_on[c];
      exp_arm[c] = m_arm[c];
    end
    if (out !== exp_out || armed !== exp_arm) begin
      if (trace_bad == 0) begin
        bad_ang = ang; bad_out = out; bad_exp = exp_out;
        bad_arm = armed; bad_earm = exp_arm;
      end
      trace_bad++;
    end
    for (int c = 0; c < CH; c++) begin
      if (acnt_step && prev_out[c] === 1'b1) high_steps[c]++;
      if (out[c] === 1'b1 && prev_out[c] !== 1'b1) begin
        rise_cnt[c]++;
        rise_ang[c] = ang;
      end
      if (out[c] !== 1'b1 && prev_out[c] === 1'b1) fall_q[c].push_back(ang);
    end
    prev_out = out;
  endtask

  task automatic idle(input int n);
    acnt_step = 1'b0;
    repeat (n) tick();
  endtask

  // one angle step, sometimes preceded by an idle cycle with a junk angle
  task automatic step_once();
    if ($urandom_range(0, 15) == 0) begin
      acnt_step = 1'b0;
      acnt = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, TOP)) : AW'(1152);
      tick();
    end
    acnt = AW'(cur_ang);
    acnt_step = 1'b1;
    tick();
    last_ang = cur_ang;
    cur_ang = (cur_ang == TOP) ? 0 : cur_ang + 1;
    acnt_step = 1'b0;
  endtask

  // step until the given angle has just been issued (always at least one step)
  task automatic run_until(input int target);
    int guard = 0;
    do begin
      step_once();
      guard++;
    end while (last_ang != target && guard < 2 * N);
  endtask

  task automatic write_cfg(input int ch, input int set_a, input int off_a, input bit en);
    wr_ch = 2'(ch);
    wr_set = AW'(set_a);
    wr_rst = AW'(off_a);
    wr_chen = en;
    wr_ena = 1'b1;
    acnt_step = 1'b0;
    tick();
    wr_ena = 1'b0;
  endtask

  task automatic clear_events();
    for (int c = 0; c < CH; c++) begin
      rise_cnt[c] = 0;
      rise_ang[c] = -1;
      high_steps[c] = 0;
      fall_q[c].delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; hwag_start = 1'b1;
    wr_ch = 2'd0; wr_set = AW'(100); wr_rst = AW'(200); wr_chen = 1'b1; wr_ena = 1'b1;
    acnt_step = 1'b0;
    tick(); tick();
    checks++;
    if (out !== 3'b000) begin errors++; $display("[TB] FAIL reset_out: got %b, expected 000", out); end
    checks++;
    if (armed !== 3'b000) begin errors++; $display("[TB] FAIL reset_armed: got %b, expected 000", armed); end
    wr_ena = 1'b0; rst = 1'b0;
    idle(3);
    checks++;
    if (armed !== 3'b000) begin errors++; $display("[TB] FAIL reset_no_cfg: armed %b, expected 000", armed); end
    checks++;
    if (trace_bad !== 0) begin
      errors++;
      $display("[TB] FAIL reset_trace: %0d cycles off, first at angle %0d out=%b armed=%b expected out=%b armed=%b",
               trace_bad, bad_ang, bad_out, bad_arm, bad_exp, bad_earm);
    end
    trace_bad = 0;
  endtask

  task automatic test_basic_pulse();
    int f;
    hwag_start = 1'b0;
    write_cfg(0, 1152, 1216, 1'b1);
    write_cfg(1, 7600, 64, 1'b1);
    idle(1);
    hwag_start = 1'b1;
    idle(1);
    checks++;
    if (armed !== 3'b011) begin errors++; $display("[TB] FAIL basic_armed: got %b, expected 011", armed); end
    clear_events();
    cur_ang = 0;
    run_until(TOP);
    run_until(100);
    checks++;
    if (rise_cnt[0] != 1 || rise_ang[0] != 1152) begin
      errors++; $display("[TB] FAIL basic_ch0_rise: count %0d angle %0d, expected 1 at 1152", rise_cnt[0], rise_ang[0]);
    end
    f = (fall_q[0].size() > 0) ? fall_q[0][0] : -1;
    checks++;
    if (fall_q[0].size() != 1 || f != 1216) begin
      errors++; $display("[TB] FAIL basic_ch0_fall: %0d falls first at %0d, expected 1 at 1216", fall_q[0].size(), f);
    end
    checks++;
    if (high_steps[0] != exp_width(1152, 1216)) begin
      errors++; $display("[TB] FAIL basic_ch0_width: got %0d, expected %0d", high_steps[0], exp_width(1152, 1216));
    end
    checks++;
    if (rise_cnt[1] != 1 || rise_ang[1] != 7600) begin
      errors++; $display("[TB] FAIL wrap_ch1_rise: count %0d angle %0d, expected 1 at 7600", rise_cnt[1], rise_ang[1]);
    end
    f = (fall_q[1].size() > 0) ? fall_q[1][0] : -1;
    checks++;
    if (fall_q[1].size() != 1 || f != 64) begin
      errors++; $display("[TB] FAIL wrap_ch1_fall: %0d falls first at %0d, expected 1 at 64", fall_q[1].size(), f);
    end
    checks++;
    if (high_steps[1] != exp_width(7600, 64)) begin
      errors++; $display("[TB] FAIL wrap_ch1_width: got %0d, expected %0d", high_steps[1], exp_width(7600, 64));
    end
    checks++;
    if (trace_bad !== 0) begin
      errors++;
      $display("[TB] FAIL basic_trace: %0d cycles off, first at angle %0d out=%b armed=%b expected out=%b armed=%b",
               trace_bad, bad_ang, bad_out, bad_arm, bad_exp, bad_earm);
    end
    trace_bad = 0;
  endtask

  task automatic test_enable_in_window();
    run_until(3100);
    write_cfg(2, 3072, 3136, 1'b1);
    clear_events();
    repeat (5) step_once();
    checks++;
    if (out[2] !== 1'b0) begin errors++; $display("[TB] FAIL enable_in_window_out: got %b, expected 0", out[2]); end
    run_until(3071);
    checks++;
    if (rise_cnt[2] != 0) begin errors++; $display("[TB] FAIL enable_early_pulse: %0d rises, expected 0", rise_cnt[2]); end
    run_until(3200);
    checks++;
    if (rise_cnt[2] != 1 || rise_ang[2] != 3072) begin
      errors++; $display("[TB] FAIL enable_first_rise: count %0d angle %0d, expected 1 at 3072", rise_cnt[2], rise_ang[2]);
    end
    checks++;
    if (high_steps[2] != exp_width(3072, 3136)) begin
      errors++; $display("[TB] FAIL enable_width: got %0d, expected %0d", high_steps[2], exp_width(3072, 3136));
    end
    checks++;
    if (trace_bad !== 0) begin
      errors++;
      $display("[TB] FAIL enable_trace: %0d cycles off, first at angle %0d out=%b armed=%b expected out=%b armed=%b",
               trace_bad, bad_ang, bad_out, bad_arm, bad_exp, bad_earm);
    end
    trace_bad = 0;
  endtask

  task automatic test_start_drop();
    run_until(1190);
    checks++;
    if (out[0] !== 1'b1) begin errors++; $display("[TB] FAIL drop_pre_out: got %b, expected 1", out[0]); end
    hwag_start = 1'b0;
    idle(1);
    checks++;
    if (out[0] !== 1'b0 || armed[0] !== 1'b0) begin
      errors++; $display("[TB] FAIL drop_forces_off: out %b armed %b, expected 0 0", out[0], armed[0]);
    end
    repeat (3) step_once();
    hwag_start = 1'b1;
    idle(1);
    checks++;
    if (armed !== 3'b111) begin errors++; $display("[TB] FAIL restart_armed: got %b, expected 111", armed); end
    clear_events();
    run_until(1151);
    checks++;
    if (rise_cnt[0] != 0) begin errors++; $display("[TB] FAIL restart_early_pulse: %0d rises, expected 0", rise_cnt[0]); end
    run_until(1300);
    checks++;
    if (rise_cnt[0] != 1 || rise_ang[0] != 1152) begin
      errors++; $display("[TB] FAIL restart_rise: count %0d angle %0d, expected 1 at 1152", rise_cnt[0], rise_ang[0]);
    end
    checks++;
    if (trace_bad !== 0) begin
      errors++;
      $display("[TB] FAIL drop_trace: %0d cycles off, first at angle %0d out=%b armed=%b expected out=%b armed=%b",
               trace_bad, bad_ang, bad_out, bad_arm, bad_exp, bad_earm);
    end
    trace_bad = 0;
  endtask

  task automatic test_rewrite();
    int first_exp;
    int f0;
    int f1;
`ifdef HWAG_OUT_SHADOW_EN
    first_exp = 1216;
`else
    first_exp = 1300;
`endif
    run_until(1180);
    checks++;
    if (out[0] !== 1'b1) begin errors++; $display("[TB] FAIL rewrite_pre_out: got %b, expected 1", out[0]); end
    write_cfg(0, 1152, 1300, 1'b1);
    clear_events();
    run_until(1400);
    run_until(1400);
    f0 = (fall_q[0].size() > 0) ? fall_q[0][0] : -1;
    f1 = (fall_q[0].size() > 1) ? fall_q[0][1] : -1;
    checks++;
    if (fall_q[0].size() != 2) begin
      errors++; $display("[TB] FAIL rewrite_fall_count: got %0d, expected 2", fall_q[0].size());
    end
    checks++;
    if (f0 != first_exp) begin errors++; $display("[TB] FAIL rewrite_current_end: got %0d, expected %0d", f0, first_exp); end
    checks++;
    if (f1 != 1300) begin errors++; $display("[TB] FAIL rewrite_next_end: got %0d, expected 1300", f1); end
    checks++;
    if (trace_bad !== 0) begin
      errors++;
      $display("[TB] FAIL rewrite_trace: %0d cycles off, first at angle %0d out=%b armed=%b expected out=%b armed=%b",
               trace_bad, bad_ang, bad_out, bad_arm, bad_exp, bad_earm);
    end
    trace_bad = 0;
  endtask

  task automatic test_reset_mid();
    run_until(1250);
    checks++;
    if (out[0] !== 1'b1) begin errors++; $display("[TB] FAIL resetmid_pre_out: got %b, expected 1", out[0]); end
    write_cfg(CH, 1260, 1270, 1'b0);
    idle(1);
    checks++;
    if (armed !== 3'b111 || out[0] !== 1'b1) begin
      errors++; $display("[TB] FAIL bad_index_write: armed %b out0 %b, expected 111 1", armed, out[0]);
    end
    rst = 1'b1;
    wr_ch = 2'd0; wr_set = AW'(5); wr_rst = AW'(6); wr_chen = 1'b1; wr_ena = 1'b1;
    idle(1);
    checks++;
    if (out !== 3'b000 || armed !== 3'b000) begin
      errors++; $display("[TB] FAIL resetmid_clear: out %b armed %b, expected 000 000", out, armed);
    end
    rst = 1'b0; wr_ena = 1'b0;
    idle(3);
    checks++;
    if (armed !== 3'b000) begin errors++; $display("[TB] FAIL resetmid_cfg_cleared: armed %b, expected 000", armed); end
    checks++;
    if (trace_bad !== 0) begin
      errors++;
      $display("[TB] FAIL resetmid_trace: %0d cycles off, first at angle %0d out=%b armed=%b expected out=%b armed=%b",
               trace_bad, bad_ang, bad_out, bad_arm, bad_exp, bad_earm);
    end
    trace_bad = 0;
  endtask

  task automatic test_equal_and_range();
    hwag_start = 1'b0;
    write_cfg(2, 1300, 1300, 1'b1);
    write_cfg(1, 8000, 1310, 1'b1);
    write_cfg(0, 1280, 9000, 1'b1);
    write_cfg(CH, 0, 0, 1'b0);
    idle(1);
    hwag_start = 1'b1;
    idle(1);
    checks++;
    if (armed !== 3'b111) begin errors++; $display("[TB] FAIL equal_armed: got %b, expected 111", armed); end
    clear_events();
    run_until(1320);
    run_until(1320);
    checks++;
    if (rise_cnt[2] != 1 || fall_q[2].size() != 1 || high_steps[2] != exp_width(1300, 1300)) begin
      errors++;
      $display("[TB] FAIL equal_full_cycle: rises %0d falls %0d width %0d, expected 1 1 %0d",
               rise_cnt[2], fall_q[2].size(), high_steps[2], exp_width(1300, 1300));
    end
    checks++;
    if (rise_cnt[1] != 0) begin errors++; $display("[TB] FAIL set_beyond_top: %0d rises, expected 0", rise_cnt[1]); end
    checks++;
    if (rise_cnt[0] != 1 || fall_q[0].size() != 0 || out[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_beyond_top: rises %0d falls %0d out %b, expected 1 0 1",
               rise_cnt[0], fall_q[0].size(), out[0]);
    end
    checks++;
    if (trace_bad !== 0) begin
      errors++;
      $display("[TB] FAIL equal_trace: %0d cycles off, first at angle %0d out=%b armed=%b expected out=%b armed=%b",
               trace_bad, bad_ang, bad_out, bad_arm, bad_exp, bad_earm);
    end
    trace_bad = 0;
  endtask

  // safety net so the run always ends
  initial begin
    #1500000;
    $display("[TB] FAIL timeout: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] time limit");
  end

  initial begin
    rst = 1'b1; hwag_start = 1'b0; acnt = '0; acnt_step = 1'b0;
    wr_ena = 1'b0; wr_ch = '0; wr_set = '0; wr_rst = '0; wr_chen = 1'b0;
    clear_events();
    $display("[TB] start");
    test_reset();
    test_basic_pulse();
    test_enable_in_window();
    test_start_drop();
    test_rewrite();
    test_reset_mid();
    test_equal_and_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hwag_out_bank.md
HWAG_OUT_BANK -- requirements
Module: hwag_out_bank

Interface
REQ-001 Parameter CH_NUM, default 4: number of angle output channels, range 1..16.
REQ-002 Parameter ACNT_WIDTH, default 24: width of the angle count and of the set/reset angles.
REQ-003 Parameter ACNT_TOP, default 7679: last angle of the cycle (two revolutions, 3840 angles each).
REQ-004 clk  in  1  single clock; reset is synchronous and active-high (rst).
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 hwag_start  in  1  angle generator synchronised; 0 = angle invalid.
REQ-007 acnt  in  ACNT_WIDTH  current angle count.
REQ-008 acnt_step  in  1  one-cycle pulse; acnt holds a new angle this cycle.
REQ-009 wr_ena  in  1  configuration write strobe.
REQ-010 wr_ch  in  $clog2(CH_NUM) (min 1)  target channel index.
REQ-011 wr_set  in  ACNT_WIDTH  angle at which the output turns on.
REQ-012 wr_rst  in  ACNT_WIDTH  angle at which the output turns off.
REQ-013 wr_chen  in  1  channel enable.
REQ-014 out  out  CH_NUM  channel outputs, active high, registered.
REQ-015 armed  out  CH_NUM  per-channel ARMED-or-ON status, registered.

Function
REQ-016 Each channel SHALL run an FSM with states OFF, ARMED and ON; out[i]=1 only in ON; armed[i]=1 in ARMED or ON.
REQ-017 OFF->ARMED SHALL occur when hwag_start=1 and the active enable=1.
REQ-018 ARMED->ON SHALL occur on a cycle with acnt_step=1 and acnt==set; out rises on the next clk edge (1-cycle latency).
REQ-019 ON->ARMED SHALL occur on a cycle with acnt_step=1 and acnt==rst, with the same 1-cycle latency.
REQ-020 Enabling a channel while acnt lies inside its window SHALL NOT assert out; the first pulse starts at the next set crossing.
REQ-021 Windows SHALL wrap through ACNT_TOP->0 with no special case (e.g. set=7600, rst=64 gives a 144-angle pulse).
REQ-022 set==rst SHALL cause ARMED->ON->ARMED on consecutive matches, giving a pulse of one full cycle; set or rst greater than ACNT_TOP never matches.
REQ-023 hwag_start=0 SHALL force every channel to OFF on the next edge, regardless of state.
REQ-024 Active enable=0 SHALL force that channel to OFF on the next edge.
REQ-025 A write with wr_ch>=CH_NUM SHALL be ignored.
REQ-026 acnt values without acnt_step SHALL be ignored.

Reset
REQ-027 rst=1 SHALL set all FSMs to OFF, out=0, armed=0, and all set, rst and enable registers (active and shadow) to 0; rst has priority over all other inputs.

Configuration
REQ-028 With HWAG_OUT_SHADOW_EN defined, writes SHALL go to per-channel shadow registers.
REQ-029 With HWAG_OUT_SHADOW_EN defined, shadows SHALL copy to the active registers on acnt_step with acnt==ACNT_TOP, or every cycle while hwag_start=0.
REQ-030 With HWAG_OUT_SHADOW_EN defined, a write coinciding with the copy SHALL land in the shadow and be transferred at the next copy.
REQ-031 Without HWAG_OUT_SHADOW_EN, writes SHALL update the active registers directly on the next edge, and the new values are used for matches from the following cycle.

Structure
REQ-032 Package hwag_pkg SHALL hold the default ACNT_WIDTH, the default ACNT_TOP and the channel state enum (OFF, ARMED, ON).
REQ-033 Per-channel logic (registers, two equality comparators, FSM) SHALL be sub-module hwag_out_chan, instantiated CH_NUM times by a generate loop.

Verification
REQ-034 ch0 set=1152, rst=1216, en=1, hwag_start=1, acnt stepping 0..7679 -> out[0] high from the cycle after the step at 1152 to the cycle after the step at 1216, 64 steps wide, once per cycle.
REQ-035 ch1 set=7600, rst=64 -> out[1] high across the wrap, 144 steps.
REQ-036 Enable ch2 (set=3072, rst=3136) while acnt=3100 -> no pulse until the next cycle's 3072.
REQ-037 hwag_start drops while out[0]=1 -> out[0]=0 and armed[0]=0 one cycle later; hwag_start returns -> armed[0]=1, no pulse before the next 1152.
REQ-038 With HWAG_OUT_SHADOW_EN: rewrite ch0 rst=1300 at acnt=1180 -> the current pulse still ends at 1216 and the next cycle's pulse ends at 1300. Without HWAG_OUT_SHADOW_EN: the same write ends the current pulse at 1300.
REQ-039 rst asserted mid-pulse, and a write with wr_ch=CH_NUM -> all outputs 0 and no channel registers changed.
